// File: rtl/relational_trace_checker_if.sv
// -----------------------------------------------------------------------------
// relational_trace_checker_if
//
// Observation/ISA trace bundle from the N core copies to the checker.
//
// Signals (packed per copy, copy i at [i*W +: W]):
//   obs_valid  NCOPY         per-copy commit/observation valid
//   obs_addr   NCOPY*ADDR_W  per-copy memory address (0 when no request)
//   isa_valid  NCOPY         per-ISA-copy writeback valid
//   isa_data   NCOPY*DATA_W  per-ISA-copy writeback data
//
// Modports:
//   master  trace source (verification top / core copies)
//   slave   trace consumer (relational_trace_checker)
// -----------------------------------------------------------------------------
interface relational_trace_checker_if #(
   parameter int NCOPY  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [NCOPY-1:0]        obs_valid;
   logic [NCOPY*ADDR_W-1:0] obs_addr;
   logic [NCOPY-1:0]        isa_valid;
   logic [NCOPY*DATA_W-1:0] isa_data;

   modport master (
      output obs_valid,
      output obs_addr,
      output isa_valid,
      output isa_data
   );

   modport slave (
      input obs_valid,
      input obs_addr,
      input isa_valid,
      input isa_data
   );
endinterface

// File: rtl/relational_trace_checker.sv
// -----------------------------------------------------------------------------
// relational_trace_checker
//
// Relational non-interference monitor. Compares the observation trace (commit
// valid, memory address) of every core copy against copy 0, but only while the
// ISA reference copies agree on writeback. MODE 0 compares cycle by cycle;
// MODE 1 aligns each copy's commit stream through a DEPTH-entry FIFO and
// compares the streams in commit order. All status outputs are sticky and
// registered, so they change on the edge after the offending cycle.
//
// Ports:
//   clk           clock
//   rst           synchronous, active-high reset
//   trace_i       trace bundle (slave modport)
//   assume_ok_o   1 while the ISA copies have always agreed
//   violation_o   sticky deviation flag
//   viol_cause_o  0 none, 1 commit mismatch, 2 address mismatch, 3 FIFO overflow
//   viol_copy_o   copy index responsible for the violation
//   viol_cycle_o  cycle count of the offending cycle
//   state_o       0 IDLE, 1 RUN, 2 ASSUME_FAIL, 3 VIOLATED
// -----------------------------------------------------------------------------
module relational_trace_checker #(
   parameter int NCOPY  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int MODE   = 0,
   parameter int CYC_W  = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   relational_trace_checker_if.slave    trace_i,
   output logic                         assume_ok_o,
   output logic                         violation_o,
   output logic [1:0]                   viol_cause_o,
   output logic [$clog2(NCOPY)-1:0]     viol_copy_o,
   output logic [CYC_W-1:0]             viol_cycle_o,
   output logic [1:0]                   state_o
);

   localparam int CPY_W = $clog2(NCOPY);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_RUN         = 2'd1,
      ST_ASSUME_FAIL = 2'd2,
      ST_VIOLATED    = 2'd3
   } state_e;

   localparam logic [1:0] CAUSE_COMMIT = 2'd1;
   localparam logic [1:0] CAUSE_ADDR   = 2'd2;
   localparam logic [1:0] CAUSE_OVF    = 2'd3;

   state_e             state_q;
   logic               assume_ok_q;
   logic               violation_q;
   logic [1:0]         cause_q;
   logic [CPY_W-1:0]   copy_q;
   logic [CYC_W-1:0]   vcyc_q;
   logic [CYC_W-1:0]   cyc_q, cyc_d;

   logic               run;

   // ---------------------------------------------------------------------------
   // Per-copy views of the packed trace buses
   // ---------------------------------------------------------------------------
   logic [ADDR_W-1:0]  addr [NCOPY];
   logic [DATA_W-1:0]  data [NCOPY];

   always_comb begin
      for (int i = 0; i < NCOPY; i++) begin
         addr[i] = trace_i.obs_addr[i*ADDR_W +: ADDR_W];
         data[i] = trace_i.isa_data[i*DATA_W +: DATA_W];
      end
   end

   assign run = (state_q == ST_RUN);

   // ---------------------------------------------------------------------------
   // ISA agreement: data only matters when copy 0 reports a writeback, and a
   // valid disagreement already counts as a mismatch on its own.
   // ---------------------------------------------------------------------------
   logic isa_mis;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      isa_mis = 1'b0;
      for (int i = 1; i < NCOPY; i++) begin
         if ((trace_i.isa_valid[i] != trace_i.isa_valid[0]) ||
             (trace_i.isa_valid[0] && (data[i] != data[0])))
            isa_mis = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Lockstep compare. Scanning downwards leaves the lowest offending copy in
   // the index. The address is compared even when both valids are low, since
   // the source masks idle addresses to zero.
   // ---------------------------------------------------------------------------
   logic             ls_valid_hit, ls_addr_hit;
   logic [CPY_W-1:0] ls_valid_idx, ls_addr_idx;

   always_comb begin
      ls_valid_hit = 1'b0;
      ls_valid_idx = '0;
      ls_addr_hit  = 1'b0;
      ls_addr_idx  = '0;
      for (int i = NCOPY-1; i >= 1; i--) begin
         if (trace_i.obs_valid[i] != trace_i.obs_valid[0]) begin
            ls_valid_hit = 1'b1;
            ls_valid_idx = CPY_W'(i);
         end else if (addr[i] != addr[0]) begin
            ls_addr_hit = 1'b1;
            ls_addr_idx = CPY_W'(i);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Aligned compare: one FIFO per copy. A pop happens only when every FIFO
   // holds an entry (registered occupancy), and it pops all of them at once so
   // the heads always belong to the same commit number.
   // ---------------------------------------------------------------------------
   logic [ADDR_W-1:0] fifo_mem_q [NCOPY][DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q [NCOPY], wr_ptr_d [NCOPY];
   logic [PTR_W-1:0]  rd_ptr_q [NCOPY], rd_ptr_d [NCOPY];
   logic [CNT_W-1:0]  cnt_q    [NCOPY], cnt_d    [NCOPY];
   logic [NCOPY-1:0]  wr_en;
   logic              fifo_pop;
   logic              ovf_hit, hd_hit;
   logic [CPY_W-1:0]  ovf_idx, hd_idx;

   always_comb begin
      logic push_req;
      logic full;

      fifo_pop = run && (MODE == 1);
      for (int i = 0; i < NCOPY; i++) begin
         if (cnt_q[i] == '0) fifo_pop = 1'b0;
      end

      wr_en    = '0;
      ovf_hit  = 1'b0;
      ovf_idx  = '0;
      hd_hit   = 1'b0;
      hd_idx   = '0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      push_req = 1'b0;
      full     = 1'b0;

      for (int i = NCOPY-1; i >= 0; i--) begin
         push_req = run && (MODE == 1) && trace_i.obs_valid[i];
         full     = (cnt_q[i] == CNT_W'(DEPTH));
         // A full FIFO may still accept a push when the same cycle pops it.
         if (push_req && full && !fifo_pop) begin
            ovf_hit = 1'b1;
            ovf_idx = CPY_W'(i);
         end
         wr_en[i]    = push_req && !(full && !fifo_pop);
         wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(wr_en[i]);
         rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(fifo_pop);
         cnt_d[i]    = cnt_q[i] + CNT_W'(wr_en[i]) - CNT_W'(fifo_pop);
      end

      for (int i = NCOPY-1; i >= 1; i--) begin
         if (fifo_pop && (fifo_mem_q[i][rd_ptr_q[i]] != fifo_mem_q[0][rd_ptr_q[0]])) begin
            hd_hit = 1'b1;
            hd_idx = CPY_W'(i);
         end
      end
   end

   // NOTE: FIFO storage has no reset; occupancy counters gate every read, so stale data is never observed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCOPY; i++) begin
         if (wr_en[i]) fifo_mem_q[i][wr_ptr_q[i]] <= addr[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '{default: '0};
         rd_ptr_q <= '{default: '0};
         cnt_q    <= '{default: '0};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Deviation select. Overflow outranks a commit mismatch, which outranks an
   // address mismatch.
   // ---------------------------------------------------------------------------
   logic             dev_hit;
   logic [1:0]       dev_cause;
   logic [CPY_W-1:0] dev_copy;

   always_comb begin
      dev_hit   = 1'b0;
      dev_cause = 2'd0;
      dev_copy  = '0;
      if (MODE == 1) begin
         if (ovf_hit) begin
            dev_hit   = 1'b1;
            dev_cause = CAUSE_OVF;
            dev_copy  = ovf_idx;
         end else if (hd_hit) begin
            dev_hit   = 1'b1;
            dev_cause = CAUSE_ADDR;
            dev_copy  = hd_idx;
         end
      end else begin
         if (ls_valid_hit) begin
            dev_hit   = 1'b1;
            dev_cause = CAUSE_COMMIT;
            dev_copy  = ls_valid_idx;
         end else if (ls_addr_hit) begin
            dev_hit   = 1'b1;
            dev_cause = CAUSE_ADDR;
            dev_copy  = ls_addr_idx;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Saturating cycle counter
   // ---------------------------------------------------------------------------
   assign cyc_d = (&cyc_q) ? cyc_q : cyc_q + 1'b1;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) cyc_q <= '0;
      else     cyc_q <= cyc_d;
   end

   // ---------------------------------------------------------------------------
   // Status FSM with registered outputs. ASSUME_FAIL and VIOLATED are terminal;
   // an ISA mismatch beats an observation deviation in the same cycle.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         assume_ok_q <= 1'b1;
         violation_q <= 1'b0;
         cause_q     <= 2'd0;
         copy_q      <= '0;
         vcyc_q      <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: state_q <= ST_RUN;
            ST_RUN: begin
               if (isa_mis) begin
                  assume_ok_q <= 1'b0;
                  state_q     <= ST_ASSUME_FAIL;
               end else if (dev_hit) begin
                  violation_q <= 1'b1;
                  cause_q     <= dev_cause;
                  copy_q      <= dev_copy;
                  vcyc_q      <= cyc_q;
                  state_q     <= ST_VIOLATED;
               end
            end
            ST_ASSUME_FAIL: begin
               state_q <= ST_ASSUME_FAIL;
            end
            ST_VIOLATED: begin
               // The violation record holds, but assume_ok still tracks the ISA.
               if (isa_mis) assume_ok_q <= 1'b0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign assume_ok_o  = assume_ok_q;
   assign violation_o  = violation_q;
   assign viol_cause_o = cause_q;
   assign viol_copy_o  = copy_q;
   assign viol_cycle_o = vcyc_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_relational_trace_checker.sv
// -----------------------------------------------------------------------------
// tb_relational_trace_checker
//
// Three checker instances: lockstep NCOPY=2, aligned NCOPY=2 DEPTH=4, and
// aligned NCOPY=3 DEPTH=4, each with its own reset. Stimulus pushes the
// hand-computed expected status into a scoreboard queue right after the edge
// it applies to; a monitor pops and compares on the following falling edge.
// -----------------------------------------------------------------------------
module tb_relational_trace_checker;

   logic clk = 1'b0;
   logic rst0, rst1, rst2;

   always #5 clk = ~clk;

   relational_trace_checker_if #(.NCOPY(2), .ADDR_W(32), .DATA_W(32)) ifc0 ();
   relational_trace_checker_if #(.NCOPY(2), .ADDR_W(32), .DATA_W(32)) ifc1 ();
   relational_trace_checker_if #(.NCOPY(3), .ADDR_W(32), .DATA_W(32)) ifc2 ();

   logic        aok0, viol0, aok1, viol1, aok2, viol2;
   logic [1:0]  cause0, cause1, cause2, st0, st1, st2;
   logic        copy0, copy1;
   logic [1:0]  copy2;
   logic [15:0] cyc0, cyc1, cyc2;

   relational_trace_checker #(.NCOPY(2), .ADDR_W(32), .DATA_W(32), .DEPTH(4), .MODE(0), .CYC_W(16)) u_dut0 (
      .clk(clk), .rst(rst0), .trace_i(ifc0.slave),
      .assume_ok_o(aok0), .violation_o(viol0), .viol_cause_o(cause0),
      .viol_copy_o(copy0), .viol_cycle_o(cyc0), .state_o(st0));

   relational_trace_checker #(.NCOPY(2), .ADDR_W(32), .DATA_W(32), .DEPTH(4), .MODE(1), .CYC_W(16)) u_dut1 (
      .clk(clk), .rst(rst1), .trace_i(ifc1.slave),
      .assume_ok_o(aok1), .violation_o(viol1), .viol_cause_o(cause1),
      .viol_copy_o(copy1), .viol_cycle_o(cyc1), .state_o(st1));

   relational_trace_checker #(.NCOPY(3), .ADDR_W(32), .DATA_W(32), .DEPTH(4), .MODE(1), .CYC_W(16)) u_dut2 (
      .clk(clk), .rst(rst2), .trace_i(ifc2.slave),
      .assume_ok_o(aok2), .violation_o(viol2), .viol_cause_o(cause2),
      .viol_copy_o(copy2), .viol_cycle_o(cyc2), .state_o(st2));

   typedef struct {
      int          dut;
      string       name;
      logic        aok;
      logic        viol;
      logic [1:0]  cause;
      logic [1:0]  cp;
      logic [15:0] cyc;
      logic [1:0]  st;
   } exp_t;

   exp_t sb_q [$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic exp_t mk(input int dut, input string name, input bit aok, input bit viol,
                               input int cause, input int cp, input int cyc, input int st);
      exp_t e;
      e.dut = dut; e.name = name; e.aok = aok; e.viol = viol;
      e.cause = 2'(cause); e.cp = 2'(cp); e.cyc = 16'(cyc); e.st = 2'(st);
      return e;
   endfunction

   // Status bundle layout: {aok, viol, cause[1:0], copy[1:0], cycle[15:0], state[1:0]}
   task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got aok=%0d viol=%0d cause=%0d copy=%0d cyc=%0d st=%0d, want aok=%0d viol=%0d cause=%0d copy=%0d cyc=%0d st=%0d",
                  name, act[23], act[22], act[21:20], act[19:18], act[17:2], act[1:0],
                  req[23], req[22], req[21:20], req[19:18], req[17:2], req[1:0]);
      end
   endtask

   // Monitor: compares whatever expectations were queued for this cycle.
   exp_t        mon_e;
   logic [23:0] mon_act, mon_req;

   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         case (mon_e.dut)
            0:       mon_act = {aok0, viol0, cause0, 2'(copy0), cyc0, st0};
            1:       mon_act = {aok1, viol1, cause1, 2'(copy1), cyc1, st1};
            default: mon_act = {aok2, viol2, cause2, copy2, cyc2, st2};
         endcase
         mon_req = {mon_e.aok, mon_e.viol, mon_e.cause, mon_e.cp, mon_e.cyc, mon_e.st};
         check(mon_e.name, mon_act, mon_req);
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic tick_chk(input exp_t e);
      @(posedge clk);
      sb_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic d0(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                     input logic [1:0] iv, input logic [31:0] i0, input logic [31:0] i1);
      ifc0.obs_valid = v;
      ifc0.obs_addr  = {a1, a0};
      ifc0.isa_valid = iv;
      ifc0.isa_data  = {i1, i0};
   endtask

   task automatic d1(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
      ifc1.obs_valid = v;
      ifc1.obs_addr  = {a1, a0};
      ifc1.isa_valid = 2'b00;
      ifc1.isa_data  = '0;
   endtask

   task automatic d2(input logic [2:0] v, input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] a2);
      ifc2.obs_valid = v;
      ifc2.obs_addr  = {a2, a1, a0};
      ifc2.isa_valid = 3'b000;
      ifc2.isa_data  = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic v;
      logic w;

      rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
      d0(2'b00, 0, 0, 2'b00, 0, 0);
      d1(2'b00, 0, 0);
      d2(3'b000, 0, 0, 0);

      // Reset values on every instance.
      @(posedge clk);
      sb_q.push_back(mk(0, "reset0", 1, 0, 0, 0, 0, 0));
      sb_q.push_back(mk(1, "reset1", 1, 0, 0, 0, 0, 0));
      sb_q.push_back(mk(2, "reset2", 1, 0, 0, 0, 0, 0));
      @(negedge clk);

      // A: lockstep, 50 cycles of identical traces with varied patterns.
      rst0 = 1'b0;
      for (int c = 0; c < 50; c++) begin
         v = (c % 3) != 0;
         w = (c % 2) != 0;
         d0({v, v}, 32'h1000 + 32'(c*4), 32'h1000 + 32'(c*4), {w, w}, 32'(c*7), 32'(c*7));
         tick_chk(mk(0, "A_identical", 1, 0, 0, 0, 0, 1));
      end

      // B: commit mismatch at cycle 7, then held through cycle 20.
      rst0 = 1'b1;
      d0(2'b00, 0, 0, 2'b00, 0, 0);
      tick_chk(mk(0, "B_reset", 1, 0, 0, 0, 0, 0));
      rst0 = 1'b0;
      for (int c = 0; c < 7; c++) begin
         d0(2'b11, 32'(c), 32'(c), 2'b00, 0, 0);
         tick_chk(mk(0, "B_pre", 1, 0, 0, 0, 0, 1));
      end
      d0(2'b01, 32'h40, 32'h40, 2'b00, 0, 0);
      tick_chk(mk(0, "B_cause1", 1, 1, 1, 1, 7, 3));
      for (int c = 8; c <= 20; c++) begin
         d0(2'b10, 32'h11, 32'h22, 2'b00, 0, 0);
         tick_chk(mk(0, "B_hold", 1, 1, 1, 1, 7, 3));
      end
      d0(2'b11, 32'h8, 32'h8, 2'b01, 0, 0);
      tick_chk(mk(0, "B_isa_after_viol", 0, 1, 1, 1, 7, 3));

      // C: IDLE inputs ignored, invalid ISA data ignored, then ISA mismatch
      // together with an address mismatch -> ASSUME_FAIL, no violation.
      rst0 = 1'b1;
      d0(2'b00, 0, 0, 2'b00, 0, 0);
      tick_chk(mk(0, "C_reset", 1, 0, 0, 0, 0, 0));
      rst0 = 1'b0;
      d0(2'b01, 32'h1, 32'h2, 2'b10, 32'h3, 32'h4);
      tick_chk(mk(0, "C_idle_ignored", 1, 0, 0, 0, 0, 1));
      d0(2'b11, 32'h50, 32'h50, 2'b00, 32'h1, 32'h2);
      tick_chk(mk(0, "C_isa_invalid_data", 1, 0, 0, 0, 0, 1));
      d0(2'b11, 32'h54, 32'h54, 2'b11, 32'h9, 32'h9);
      tick_chk(mk(0, "C_isa_agree", 1, 0, 0, 0, 0, 1));
      d0(2'b11, 32'h10, 32'h20, 2'b11, 32'h4, 32'h5);
      tick_chk(mk(0, "C_assume_fail", 0, 0, 0, 0, 0, 2));
      for (int c = 4; c <= 10; c++) begin
         d0(2'b01, 32'h1, 32'h2, 2'b11, 32'h7, 32'h7);
         tick_chk(mk(0, "C_terminal", 0, 0, 0, 0, 0, 2));
      end

      // D: address compared even with both valids low.
      rst0 = 1'b1;
      d0(2'b00, 0, 0, 2'b00, 0, 0);
      tick_chk(mk(0, "D_reset", 1, 0, 0, 0, 0, 0));
      rst0 = 1'b0;
      d0(2'b00, 0, 0, 2'b00, 0, 0);
      tick_chk(mk(0, "D_idle", 1, 0, 0, 0, 0, 1));
      d0(2'b00, 32'h8, 32'hC, 2'b00, 0, 0);
      tick_chk(mk(0, "D_addr_no_valid", 1, 1, 2, 1, 1, 3));

      // E: aligned NCOPY=2. Copy 1 lags three cycles, then overflow, reset,
      // and push-and-pop on a full FIFO.
      rst1 = 1'b0;
      d1(2'b01, 32'hDEAD, 0);
      tick_chk(mk(1, "E_idle_ignored", 1, 0, 0, 0, 0, 1));
      for (int c = 1; c <= 3; c++) begin
         d1(2'b01, 32'h100 + 32'((c-1)*4), 0);
         tick_chk(mk(1, "E_copy0_commit", 1, 0, 0, 0, 0, 1));
      end
      for (int c = 4; c <= 6; c++) begin
         d1(2'b10, 0, 32'h100 + 32'((c-4)*4));
         tick_chk(mk(1, "E_copy1_late", 1, 0, 0, 0, 0, 1));
      end
      for (int c = 7; c <= 9; c++) begin
         d1(2'b00, 0, 0);
         tick_chk(mk(1, "E_drain", 1, 0, 0, 0, 0, 1));
      end
      // Four pushes fit only if the FIFOs drained to empty.
      for (int c = 10; c <= 13; c++) begin
         d1(2'b01, 32'h300 + 32'((c-10)*4), 0);
         tick_chk(mk(1, "E_fill", 1, 0, 0, 0, 0, 1));
      end
      d1(2'b01, 32'h310, 0);
      tick_chk(mk(1, "E_overflow", 1, 1, 3, 0, 14, 3));
      for (int c = 15; c <= 16; c++) begin
         d1(2'b01, 32'h320, 0);
         tick_chk(mk(1, "E_ovf_hold", 1, 1, 3, 0, 14, 3));
      end
      rst1 = 1'b1;
      d1(2'b00, 0, 0);
      tick_chk(mk(1, "E_mid_reset", 1, 0, 0, 0, 0, 0));
      rst1 = 1'b0;
      tick_chk(mk(1, "E_rerun", 1, 0, 0, 0, 0, 1));
      for (int c = 1; c <= 4; c++) begin
         d1(2'b01, 32'h400 + 32'((c-1)*4), 0);
         tick_chk(mk(1, "E_refill", 1, 0, 0, 0, 0, 1));
      end
      d1(2'b10, 0, 32'h400);
      tick_chk(mk(1, "E_copy1_one", 1, 0, 0, 0, 0, 1));
      d1(2'b11, 32'h410, 32'h404);
      tick_chk(mk(1, "E_full_pushpop", 1, 0, 0, 0, 0, 1));
      d1(2'b11, 32'h414, 32'h408);
      tick_chk(mk(1, "E_full_pushpop2", 1, 0, 0, 0, 0, 1));
      d1(2'b00, 0, 0);

      // F: aligned NCOPY=3, copy 2 lags one cycle and its third commit differs.
      rst2 = 1'b0;
      d2(3'b000, 0, 0, 0);
      tick_chk(mk(2, "F_idle", 1, 0, 0, 0, 0, 1));
      d2(3'b011, 32'h1F8, 32'h1F8, 0);
      tick_chk(mk(2, "F_c1", 1, 0, 0, 0, 0, 1));
      d2(3'b111, 32'h1FC, 32'h1FC, 32'h1F8);
      tick_chk(mk(2, "F_c2", 1, 0, 0, 0, 0, 1));
      d2(3'b111, 32'h204, 32'h204, 32'h1FC);
      tick_chk(mk(2, "F_c3", 1, 0, 0, 0, 0, 1));
      d2(3'b100, 0, 0, 32'h200);
      tick_chk(mk(2, "F_c4", 1, 0, 0, 0, 0, 1));
      d2(3'b000, 0, 0, 0);
      tick_chk(mk(2, "F_cause2", 1, 1, 2, 2, 5, 3));
      tick_chk(mk(2, "F_hold", 1, 1, 2, 2, 5, 3));
      tick_chk(mk(2, "F_hold2", 1, 1, 2, 2, 5, 3));

      tick();
      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/relational_trace_checker.md
Name: relational_trace_checker

Overview:
- Synthesizable relational non-interference monitor for N-copy verification tops.
- Compares observation traces (commit valid, memory address) of NCOPY pipelined core copies against copy 0.
- Gates the checking on an ISA-agreement condition: ISA reference copies must agree on writeback data.
- MODE 0 compares lockstep, cycle by cycle. MODE 1 aligns per-copy commit streams through FIFOs, so copies whose timing differs by up to DEPTH commits are compared in order.
- Drives sticky status outputs that formal tools bind asserts and covers to.

Parameters:
- NCOPY, 2: number of core copies (≥2); copy 0 is the comparison baseline.
- ADDR_W, 32: observation address width.
- DATA_W, 32: ISA writeback data width.
- DEPTH, 4: per-copy FIFO depth in MODE 1 (power of two, ≥2).
- MODE, 0: 0 = lockstep compare, 1 = FIFO-aligned compare.
- CYC_W, 16: cycle-counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- obs_valid  in  NCOPY  per-copy commit/observation valid.
- obs_addr  in  NCOPY*ADDR_W  per-copy memory address; copy i occupies bits [i*ADDR_W +: ADDR_W]. Already masked to 0 by the source when no memory request is made.
- isa_valid  in  NCOPY  per-ISA-copy writeback valid.
- isa_data  in  NCOPY*DATA_W  per-ISA-copy writeback data, packed the same way as obs_addr.
- assume_ok  out  1  sticky; 1 while ISA copies have always agreed.
- violation  out  1  sticky leakage/deviation flag.
- viol_cause  out  2  0 none, 1 commit mismatch, 2 address mismatch, 3 FIFO overflow.
- viol_copy  out  $clog2(NCOPY)  copy index that caused the violation.
- viol_cycle  out  CYC_W  cycle count at which the violation was detected.
- state  out  2  0 IDLE, 1 RUN, 2 ASSUME_FAIL, 3 VIOLATED.

Behaviour:
- Reset values: assume_ok=1; violation=0; viol_cause=0; viol_copy=0; viol_cycle=0; state=IDLE. All FIFOs are emptied and the cycle counter is cleared.
- Reset asserted mid-operation has the same effect; nothing survives reset.
- Cycle counter increments every non-reset cycle and saturates at all-ones.
- State IDLE:
  - Inputs are ignored.
  - The first clock edge with rst=0 moves the state to RUN.
  - Inputs presented during the IDLE cycle are never checked.
- ISA check, evaluated in RUN only: mismatch if any i has isa_valid[i]!=isa_valid[0], or isa_valid[0]=1 and isa_data[i]!=isa_data[0].
  - On mismatch, the next cycle has assume_ok=0 and state=ASSUME_FAIL.
- ASSUME_FAIL is terminal until reset. No further violations are recorded and FIFO pushes stop.
- Lockstep check (MODE 0), evaluated in RUN only: for each i≥1:
  - obs_valid[i]!=obs_valid[0] gives cause 1.
  - Otherwise obs_addr[i]!=obs_addr[0] gives cause 2.
  - Address is compared even when valid=0.
- Aligned check (MODE 1):
  - Copy i pushes obs_addr[i] into FIFO i when obs_valid[i]=1.
  - When all FIFOs are non-empty (registered occupancy), exactly one entry is popped from each FIFO.
  - Popped entries are compared; head i ≠ head 0 gives cause 2.
  - Cause 1 is not used in MODE 1.
  - A push into a full FIFO with no pop in that cycle gives cause 3. Push and pop in the same cycle on a full FIFO is legal.
  - Pointers wrap modulo DEPTH; occupancy is $clog2(DEPTH)+1 bits.
- Latency: the status update is registered, so outputs change on the clock edge after the offending cycle. In MODE 1 the offending cycle is the pop cycle.
- On a detected deviation in RUN, the next cycle sets violation=1, state=VIOLATED, and latches cause, copy and cycle.
  - viol_copy is the lowest offending index i≥1, or the lowest overflowing FIFO index.
  - Cause priority when several occur together: 3 > 1 > 2.
- Same-cycle ISA mismatch and observation deviation: ASSUME_FAIL wins and violation stays 0.
- VIOLATED is terminal until reset. A later ISA mismatch still clears assume_ok, but violation and the latched fields hold.

Test Plan:
- MODE 0, NCOPY=2: identical traces for 50 cycles → violation=0, state=1, assume_ok=1.
- MODE 0: obs_valid=2'b01 at cycle 7 after reset → next cycle violation=1, viol_cause=1, viol_copy=1, viol_cycle=7. Values hold through cycle 20.
- MODE 0: isa_data[1]=0x5 vs 0x4 with isa_valid=2'b11, and an address mismatch in the same cycle → assume_ok=0, state=2, violation=0 permanently.
- MODE 1, DEPTH=4: copy 1 commits the same addresses 0x100, 0x104, 0x108 three cycles late → no violation, all FIFOs drain to empty.
- MODE 1, DEPTH=4: copy 0 commits 5 times while copy 1 commits none → the fifth push gives viol_cause=3, viol_copy=0. Then assert rst for one cycle → all outputs return to reset values and state returns to IDLE, then RUN.
- MODE 1, NCOPY=3: copy 2's third commit has address 0x200 vs 0x204 → viol_cause=2, viol_copy=2, latched the cycle after the pop.
